rv32_mmio_uart_tx: RTL and testbench

- Transmit-only UART peripheral on the core's MMIO data bus. It is one of the NUM_MMIO slaves behind the top-level bus controller.
- It decodes memory_request_t, raises a one-cycle request_done on address hit, and returns registered read data one cycle later, matching the controller's registered selector timing.
- Written bytes go into a FIFO and are serialized 8N1 on uart_tx using a programmable baud divisor.

---
 rtl/rv32_mmio_uart_tx.sv | 258 +++++++++++++++++++++++++
 tb/tb_rv32_mmio_uart_tx.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rv32_mmio_uart_tx.sv
// Transmit-only 8N1 UART on the RV32 MMIO data bus: a four-register window,
// a TX byte FIFO and a bit-serialiser with a programmable baud divisor.

package rv32_mmio_uart_pkg;
    typedef enum logic [1:0] {
        MEM_NOP   = 2'd0,
        MEM_READ  = 2'd1,
        MEM_WRITE = 2'd2
    } mem_op_t;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        mem_op_t     op;
    } memory_request_t;
endpackage

module rv32_mmio_uart_tx
    import rv32_mmio_uart_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
    parameter int          FIFO_DEPTH  = 8,
    parameter logic [15:0] DEFAULT_DIV = 16'd868
) (
    input  logic            clk,
    input  logic            resetn,
    input  memory_request_t data_request,
    output logic            request_done,
    output logic [31:0]     read_data,
    output logic            uart_tx
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } tx_state_t;

    // Bus decode
    logic        hit_s;
    logic        rd_hit_s;
    logic        txdata_wr_s;
    logic        div_wr_s;
    logic        status_rd_s;
    logic [31:0] rdata_s;
    logic [31:0] status_s;
    logic [15:0] div_wdata_s;

    // FIFO
    logic [7:0]    fifo_mem_r [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_r;
    logic [PW-1:0] rd_ptr_r;
    logic [CW-1:0] count_r;
    logic          full_s;
    logic          empty_s;
    logic          push_s;
    logic          pop_s;
    logic          ovf_set_s;
    logic          overflow_r;
    logic [15:0]   div_r;
    logic [31:0]   read_data_r;

    // Serialiser
    tx_state_t   state_r;
    tx_state_t   state_next_s;
    logic [15:0] baud_cnt_r;
    logic [15:0] baud_next_s;
    logic [2:0]  bit_idx_r;
    logic [2:0]  bit_idx_next_s;
    logic [7:0]  shift_r;
    logic [7:0]  shift_next_s;
    logic [15:0] div_shadow_r;
    logic [15:0] div_shadow_next_s;
    logic        tx_r;
    logic        tx_next_s;
    logic        bit_end_s;

    // Address decode, register-select and side-effect strobes
    always_comb begin
        hit_s       = (data_request.addr[31:4] == BASE_ADDR[31:4]) && (data_request.op != MEM_NOP);
        rd_hit_s    = hit_s && (data_request.op == MEM_READ);
        txdata_wr_s = 1'b0;
        div_wr_s    = 1'b0;
        status_rd_s = 1'b0;
        if (hit_s && (data_request.op == MEM_WRITE)) begin
            txdata_wr_s = (data_request.addr[3:2] == 2'd0);
            div_wr_s    = (data_request.addr[3:2] == 2'd2);
        end else begin
            status_rd_s = rd_hit_s && (data_request.addr[3:2] == 2'd1);
        end
    end

    assign full_s    = (count_r == FULL_CNT);
    assign empty_s   = (count_r == {CW{1'b0}});
    assign push_s    = txdata_wr_s && !full_s;
    assign ovf_set_s = txdata_wr_s && full_s;

    // Read mux; the snapshot reflects state before this cycle's updates
    always_comb begin
        status_s = {20'd0, 4'(count_r), 4'd0, overflow_r, empty_s, full_s, (state_r != S_IDLE)};
        case (data_request.addr[3:2])
            2'd1:    rdata_s = status_s;
            2'd2:    rdata_s = {16'd0, div_r};
            default: rdata_s = 32'd0;
        endcase
    end

    // Divisor write value with lower clamp
    always_comb begin
        if (data_request.data[15:0] < 16'd2) begin
            div_wdata_s = 16'd2;
        end else begin
            div_wdata_s = data_request.data[15:0];
        end
    end

    // Registered read data, overflow flag and divisor register
    always_ff @(posedge clk) begin
        if (!resetn) begin
            read_data_r <= 32'd0;
            overflow_r  <= 1'b0;
            div_r       <= DEFAULT_DIV;
        end else begin
            read_data_r <= rd_hit_s ? rdata_s : 32'd0;
            if (ovf_set_s) begin
                overflow_r <= 1'b1;
            end else if (status_rd_s) begin
                overflow_r <= 1'b0;
            end
            if (div_wr_s) begin
                div_r <= div_wdata_s;
            end
        end
    end

    // FIFO storage: contents are only meaningful below count_r, so no reset
    always_ff @(posedge clk) begin
        if (push_s) begin
            fifo_mem_r[wr_ptr_r] <= data_request.data[7:0];
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PW'(1);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    assign bit_end_s = (baud_cnt_r == (div_shadow_r - 16'd1));

    // Serialiser next-state; uart_tx is computed one step ahead so it leaves a flop
    always_comb begin
        state_next_s      = state_r;
        baud_next_s       = baud_cnt_r;
        bit_idx_next_s    = bit_idx_r;
        shift_next_s      = shift_r;
        div_shadow_next_s = div_shadow_r;
        tx_next_s         = tx_r;
        pop_s             = 1'b0;
        case (state_r)
            S_IDLE: begin
                tx_next_s = 1'b1;
                if (!empty_s) begin
                    pop_s             = 1'b1;
                    shift_next_s      = fifo_mem_r[rd_ptr_r];
                    baud_next_s       = 16'd0;
                    div_shadow_next_s = div_r;
                    state_next_s      = S_START;
                    tx_next_s         = 1'b0;
                end else begin
                    state_next_s = S_IDLE;
                end
            end
            S_START: begin
                if (bit_end_s) begin
                    baud_next_s    = 16'd0;
                    bit_idx_next_s = 3'd0;
                    state_next_s   = S_DATA;
                    tx_next_s      = shift_r[0];
                end else begin
                    baud_next_s = baud_cnt_r + 16'd1;
                end
            end
            S_DATA: begin
                if (bit_end_s) begin
                    baud_next_s = 16'd0;
                    if (bit_idx_r == 3'd7) begin
                        state_next_s = S_STOP;
                        tx_next_s    = 1'b1;
                    end else begin
                        bit_idx_next_s = bit_idx_r + 3'd1;
                        shift_next_s   = {1'b0, shift_r[7:1]};
                        tx_next_s      = shift_r[1];
                    end
                end else begin
                    baud_next_s = baud_cnt_r + 16'd1;
                end
            end
            S_STOP: begin
                if (bit_end_s) begin
                    baud_next_s  = 16'd0;
                    state_next_s = S_IDLE;
                    tx_next_s    = 1'b1;
                end else begin
                    baud_next_s = baud_cnt_r + 16'd1;
                end
            end
            default: begin
                state_next_s = S_IDLE;
                tx_next_s    = 1'b1;
            end
        endcase
    end

    // Serialiser state register; reset aborts any frame with the line high
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_r      <= S_IDLE;
            baud_cnt_r   <= 16'd0;
            bit_idx_r    <= 3'd0;
            shift_r      <= 8'd0;
            div_shadow_r <= DEFAULT_DIV;
            tx_r         <= 1'b1;
        end else begin
            state_r      <= state_next_s;
            baud_cnt_r   <= baud_next_s;
            bit_idx_r    <= bit_idx_next_s;
            shift_r      <= shift_next_s;
            div_shadow_r <= div_shadow_next_s;
            tx_r         <= tx_next_s;
        end
    end

    assign request_done = hit_s;
    assign read_data    = read_data_r;
    assign uart_tx      = tx_r;

endmodule

// File: tb/tb_rv32_mmio_uart_tx.sv
// Self-checking bench for rv32_mmio_uart_tx: bus accesses plus a line-level
// reference that predicts the uart_tx waveform from bytes and divisors.

module tb_rv32_mmio_uart_tx;
    import rv32_mmio_uart_pkg::*;

    localparam logic [31:0] BASE  = 32'h8000_0000;
    localparam int          DEPTH = 8;

    logic            clk = 1'b0;
    logic            resetn = 1'b0;
    memory_request_t req;
    logic            request_done;
    logic [31:0]     read_data;
    logic            uart_tx;

    int   cyc = 0;
    int   last_cyc = 0;
    int   errors = 0;
    int   checks = 0;
    logic txlog [int];

    rv32_mmio_uart_tx #(
        .BASE_ADDR  (BASE),
        .FIFO_DEPTH (DEPTH),
        .DEFAULT_DIV(16'd868)
    ) dut (
        .clk         (clk),
        .resetn      (resetn),
        .data_request(req),
        .request_done(request_done),
        .read_data   (read_data),
        .uart_tx     (uart_tx)
    );

    always #5 clk = ~clk;

    // cyc = index of the cycle that began at the latest posedge
    always @(posedge clk) cyc <= cyc + 1;

    // line log, one sample per cycle away from the active edge
    always @(negedge clk) txlog[cyc] = uart_tx;

    // one bus cycle: called at a negedge, returns at the next negedge
    task automatic bus(input mem_op_t op, input logic [31:0] addr, input logic [31:0] data,
                       output logic done, output logic [31:0] rdv);
        last_cyc = cyc;
        req.op   = op;
        req.addr = addr;
        req.data = data;
        #1 done = request_done;
        @(negedge clk);
        rdv    = read_data;
        req.op = MEM_NOP;
    endtask

    task automatic wr(input logic [3:0] off, input logic [31:0] d);
        logic        dn;
        logic [31:0] r;
        bus(MEM_WRITE, BASE + {28'd0, off}, d, dn, r);
    endtask

    task automatic rd(input logic [3:0] off, output logic [31:0] d, output logic dn);
        bus(MEM_READ, BASE + {28'd0, off}, 32'd0, dn, d);
    endtask

    task automatic wait_to(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    // Reference line model: each frame is start(0), 8 data bits LSB first,
    // stop(1), each div cycles long, followed by one idle-high cycle.
    task automatic check_frames(input int t0, input logic [7:0] bq[$], input int dq[$],
                                input string name);
        int   t;
        int   end_c;
        int   d;
        int   bad_c;
        logic got;
        logic wexp;
        logic e;
        end_c = t0;
        foreach (dq[k]) end_c += 10 * dq[k] + 1;
        wait_to(end_c + 1);
        checks++;
        if (txlog[t0 - 1] !== 1'b1) begin
            errors++;
            $display("FAIL %s idle_before_start: uart_tx at cycle %0d got %b want 1", name, t0 - 1, txlog[t0 - 1]);
        end
        t = t0;
        foreach (bq[k]) begin
            d     = dq[k];
            bad_c = -1;
            got   = 1'b0;
            wexp  = 1'b0;
            for (int j = 0; j <= 10 * d; j++) begin
                if (j >= 9 * d)  e = 1'b1;
                else if (j < d)  e = 1'b0;
                else             e = bq[k][j / d - 1];
                if (txlog[t + j] !== e && bad_c < 0) begin
                    bad_c = t + j;
                    got   = txlog[t + j];
                    wexp  = e;
                end
            end
            checks++;
            if (bad_c >= 0) begin
                errors++;
                $display("FAIL %s frame%0d byte=%h div=%0d: uart_tx at cycle %0d got %b want %b",
                         name, k, bq[k], d, bad_c, got, wexp);
            end
            t += 10 * d + 1;
        end
    endtask

    task automatic test_reset;
        logic [31:0] r;
        logic        dn;
        resetn = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (uart_tx !== 1'b1) begin errors++; $display("FAIL reset_tx got %b want 1", uart_tx); end
        checks++; if (read_data !== 32'd0) begin errors++; $display("FAIL reset_rdata got %h want 0", read_data); end
        checks++; if (request_done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", request_done); end
        resetn = 1'b1;
        @(negedge clk);
        rd(4'h4, r, dn);
        checks++; if (dn !== 1'b1 || r !== 32'h4) begin errors++; $display("FAIL reset_status done=%b got %h want 00000004", dn, r); end
        rd(4'h8, r, dn);
        checks++; if (dn !== 1'b1 || r !== 32'h364) begin errors++; $display("FAIL reset_div done=%b got %h want 00000364", dn, r); end
        @(negedge clk);
        checks++; if (read_data !== 32'd0) begin errors++; $display("FAIL rdata_hold got %h want 0", read_data); end
        rd(4'h0, r, dn);
        checks++; if (r !== 32'd0) begin errors++; $display("FAIL txdata_read got %h want 0", r); end
        wr(4'h8, 32'd1);
        rd(4'h8, r, dn);
        checks++; if (r !== 32'd2) begin errors++; $display("FAIL div_clamp1 got %h want 2", r); end
        wr(4'h8, 32'd0);
        rd(4'h8, r, dn);
        checks++; if (r !== 32'd2) begin errors++; $display("FAIL div_clamp0 got %h want 2", r); end
        wr(4'h8, 32'hABCD_0007);
        wr(4'hC, 32'h55);
        bus(MEM_WRITE, BASE + 32'h18, 32'd3, dn, r);
        checks++; if (dn !== 1'b0) begin errors++; $display("FAIL oow_write_done got %b want 0", dn); end
        rd(4'hA, r, dn);
        checks++; if (r !== 32'd7) begin errors++; $display("FAIL div_upper_bits got %h want 7", r); end
        rd(4'hC, r, dn);
        checks++; if (dn !== 1'b1 || r !== 32'd0) begin errors++; $display("FAIL reserved done=%b got %h want 0", dn, r); end
        rd(4'h8, r, dn);
        bus(MEM_READ, BASE + 32'h10, 32'd0, dn, r);
        checks++; if (dn !== 1'b0 || r !== 32'd0) begin errors++; $display("FAIL oow_read done=%b got %h want 0/0", dn, r); end
        bus(MEM_READ, BASE - 32'd4, 32'd0, dn, r);
        checks++; if (dn !== 1'b0) begin errors++; $display("FAIL below_base_done got %b want 0", dn); end
        bus(MEM_NOP, BASE + 32'h4, 32'd0, dn, r);
        checks++; if (dn !== 1'b0 || r !== 32'd0) begin errors++; $display("FAIL nop_in_window done=%b got %h want 0/0", dn, r); end
    endtask

    task automatic test_a5;
        logic [31:0] r;
        logic        dn;
        int          s;
        logic [7:0]  bq[$];
        int          dq[$];
        wr(4'h8, 32'd4);
        bus(MEM_WRITE, BASE, 32'hFFFF_FFA5, dn, r);
        checks++; if (dn !== 1'b1) begin errors++; $display("FAIL a5_done got %b want 1", dn); end
        s = last_cyc + 2;
        wait_to(s + 39);
        rd(4'h4, r, dn);
        checks++; if (r !== 32'h5) begin errors++; $display("FAIL a5_busy_last got %h want 00000005", r); end
        rd(4'h4, r, dn);
        checks++; if (r !== 32'h4) begin errors++; $display("FAIL a5_idle_after got %h want 00000004", r); end
        bq.push_back(8'hA5); dq.push_back(4);
        check_frames(s, bq, dq, "a5");
    endtask

    task automatic test_random;
        logic [7:0] bq[$];
        int         dq[$];
        int         d, n, w;
        for (int it = 0; it < 3; it++) begin
            bq.delete(); dq.delete();
            d = $urandom_range(2, 6);
            n = $urandom_range(1, 5);
            wr(4'h8, 32'(d));
            w = cyc;
            for (int k = 0; k < n; k++) begin
                bq.push_back(8'($urandom));
                dq.push_back(d);
                wr(4'h0, {24'd0, bq[k]});
            end
            check_frames(w + 2, bq, dq, "random");
        end
    endtask

    task automatic test_overflow;
        logic [31:0] r;
        logic        dn;
        int          n, w, acc, held, nd;
        logic [31:0] exp_s;
        logic [7:0]  all[$];
        logic [7:0]  bq[$];
        int          dq[$];
        wr(4'h8, 32'd100);
        n  = $urandom_range(DEPTH + 2, DEPTH + 4);
        w  = cyc;
        nd = 0;
        for (int k = 0; k < n; k++) begin
            all.push_back(8'($urandom));
            bus(MEM_WRITE, BASE, {24'd0, all[k]}, dn, r);
            if (dn !== 1'b1) nd++;
        end
        checks++; if (nd != 0) begin errors++; $display("FAIL ovf_write_done missing=%0d want 0", nd); end
        // the first byte leaves for the shifter at once, so DEPTH+1 bytes fit
        acc   = (n < DEPTH + 1) ? n : DEPTH + 1;
        held  = acc - 1;
        exp_s = 32'((held << 8) | ((n > acc) ? 8 : 0) | ((held == DEPTH) ? 2 : 0) | ((held == 0) ? 4 : 0) | 1);
        rd(4'h4, r, dn);
        checks++; if (r !== exp_s) begin errors++; $display("FAIL ovf_status1 got %h want %h", r, exp_s); end
        rd(4'h4, r, dn);
        checks++; if (r !== (exp_s & ~32'h8)) begin errors++; $display("FAIL ovf_status2 got %h want %h", r, exp_s & ~32'h8); end
        for (int k = 0; k < acc; k++) begin
            bq.push_back(all[k]);
            dq.push_back(100);
        end
        check_frames(w + 2, bq, dq, "overflow");
    endtask

    task automatic test_back_to_back;
        logic [31:0] r;
        logic        dn;
        int          w;
        logic [7:0]  bq[$];
        int          dq[$];
        bq.push_back(8'($urandom)); bq.push_back(8'($urandom));
        dq.push_back(4); dq.push_back(4);
        wr(4'h8, 32'd4);
        w = cyc;
        wr(4'h0, {24'd0, bq[0]});
        wr(4'h0, {24'd0, bq[1]});
        rd(4'h4, r, dn);
        checks++; if (r !== 32'h101) begin errors++; $display("FAIL pushpop_status got %h want 00000101", r); end
        check_frames(w + 2, bq, dq, "pushpop");
    endtask

    task automatic test_div_change;
        int         w;
        logic [7:0] bq[$];
        int         dq[$];
        bq.push_back(8'($urandom)); bq.push_back(8'($urandom));
        dq.push_back(4); dq.push_back(8);
        wr(4'h8, 32'd4);
        w = cyc;
        wr(4'h0, {24'd0, bq[0]});
        wr(4'h0, {24'd0, bq[1]});
        wait_to(w + 2 + 10);
        wr(4'h8, 32'd8);
        check_frames(w + 2, bq, dq, "divchange");
    endtask

    task automatic test_reset_mid;
        logic [31:0] r;
        logic        dn;
        int          w, c0, bad;
        wr(4'h8, 32'd4);
        w = cyc;
        for (int k = 0; k < 3; k++) wr(4'h0, 32'($urandom));
        wait_to(w + 2 + 12);
        resetn = 1'b0;
        @(negedge clk);
        checks++; if (uart_tx !== 1'b1) begin errors++; $display("FAIL midreset_tx got %b want 1", uart_tx); end
        @(negedge clk);
        resetn = 1'b1;
        c0 = cyc;
        wait_to(c0 + 21);
        bad = 0;
        for (int c = c0; c < c0 + 20; c++) if (txlog[c] !== 1'b1) bad++;
        checks++; if (bad != 0) begin errors++; $display("FAIL midreset_line low_cycles got %0d want 0", bad); end
        rd(4'h4, r, dn);
        checks++; if (r !== 32'h4) begin errors++; $display("FAIL midreset_status got %h want 00000004", r); end
        rd(4'h8, r, dn);
        checks++; if (r !== 32'h364) begin errors++; $display("FAIL midreset_div got %h want 00000364", r); end
    endtask

    initial begin
        req.op   = MEM_NOP;
        req.addr = 32'd0;
        req.data = 32'd0;
        @(negedge clk);
        test_reset;
        test_a5;
        test_random;
        test_back_to_back;
        test_div_change;
        test_overflow;
        test_reset_mid;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
